// File: rtl/mem_req_sched.sv
// mem_req_sched: three-client (IF/LD/ST) request scheduler in front of the byte-serial RAM engine.
// One pending slot per client, single outstanding engine transaction, flush and IO write spacing.
module mem_req_sched #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned IO_GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_in,
  input  logic        io_buffer_full_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ack_out,
  output logic [31:0] if_data_out,
  input  logic        ld_req_in,
  input  logic [31:0] ld_addr_in,
  input  logic [1:0]  ld_len_in,
  output logic        ld_ack_out,
  output logic [31:0] ld_data_out,
  input  logic        st_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [1:0]  st_len_in,
  input  logic [31:0] st_data_in,
  output logic        st_ack_out,
  output logic        eng_start_out,
  output logic        eng_write_out,
  output logic [31:0] eng_addr_out,
  output logic [1:0]  eng_len_out,
  output logic [31:0] eng_wdata_out,
  input  logic        eng_done_in,
  input  logic [31:0] eng_rdata_in
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned GW = (IO_GAP > 1) ? $clog2(IO_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LD   = 2'd2;
  localparam logic [1:0] OWN_ST   = 2'd3;

  // Sub-word loads return zero-extended data.
  function automatic logic [31:0] ld_extend(input logic [31:0] data, input logic [1:0] len);
    logic [31:0] res;
    case (len)
      2'd0:    res = {24'h000000, data[7:0]};
      2'd1:    res = {16'h0000, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [1:0]      owner_r;
  logic [SW-1:0]   starve_r;
  logic [GW-1:0]   gap_r;
  logic            start_r;

  logic            if_v_r, ld_v_r, st_v_r;
  logic [31:0]     if_addr_r, ld_addr_r, st_addr_r, st_data_r;
  logic [1:0]      ld_len_r, st_len_r;

  logic [1:0]      grant_s;
  logic            ack_fire_s;
  logic            st_ok_s, ld_ok_s, if_ok_s;
  logic            io_st_owner_s;

  assign io_st_owner_s = (owner_r == OWN_ST) && (eng_addr_out[17:16] == 2'b11);
  assign eng_start_out = start_r & rdy;

  // Winner selection in IDLE and ack qualification in WAIT.
  always_comb begin
    grant_s    = OWN_NONE;
    ack_fire_s = 1'b0;
    st_ok_s    = st_v_r && !((st_addr_r[17:16] == 2'b11) && io_buffer_full_in);
    ld_ok_s    = ld_v_r && !clear_in;
    if_ok_s    = if_v_r && !clear_in;
    if (state_r == S_IDLE) begin
      if (if_ok_s && (starve_r == SW'(STARVE_LIMIT))) begin
        grant_s = OWN_IF;
      end else if (st_ok_s) begin
        grant_s = OWN_ST;
      end else if (ld_ok_s) begin
        grant_s = OWN_LD;
      end else if (if_ok_s) begin
        grant_s = OWN_IF;
      end else begin
        grant_s = OWN_NONE;
      end
    end else begin
      grant_s = OWN_NONE;
    end
    // A flush kills the result of a speculative (IF/LD) transaction.
    if ((state_r == S_WAIT) && eng_done_in) begin
      ack_fire_s = (owner_r == OWN_ST) || !clear_in;
    end else begin
      ack_fire_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_s != OWN_NONE) state_nxt_s = S_WAIT;
        else                     state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (eng_done_in)                           state_nxt_s = io_st_owner_s ? S_GAP : S_IDLE;
        else if (clear_in && (owner_r != OWN_ST))  state_nxt_s = S_DRAIN;
        else                                       state_nxt_s = S_WAIT;
      end
      S_DRAIN: begin
        if (eng_done_in) state_nxt_s = S_IDLE;
        else             state_nxt_s = S_DRAIN;
      end
      S_GAP: begin
        if (gap_r == GW'(IO_GAP - 1)) state_nxt_s = S_IDLE;
        else                          state_nxt_s = S_GAP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)      state_r <= S_IDLE;
    else if (rdy) state_r <= state_nxt_s;
  end

  // Client slots: accept only into an empty slot; flush drops IF/LD including same-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_v_r    <= 1'b0;
      ld_v_r    <= 1'b0;
      st_v_r    <= 1'b0;
      if_addr_r <= 32'h0;
      ld_addr_r <= 32'h0;
      st_addr_r <= 32'h0;
      st_data_r <= 32'h0;
      ld_len_r  <= 2'd0;
      st_len_r  <= 2'd0;
    end else if (rdy) begin
      if (clear_in || (grant_s == OWN_IF)) begin
        if_v_r <= 1'b0;
      end else if (if_req_in && !if_v_r) begin
        if_v_r    <= 1'b1;
        if_addr_r <= if_addr_in;
      end
      if (clear_in || (grant_s == OWN_LD)) begin
        ld_v_r <= 1'b0;
      end else if (ld_req_in && !ld_v_r) begin
        ld_v_r    <= 1'b1;
        ld_addr_r <= ld_addr_in;
        ld_len_r  <= ld_len_in;
      end
      if (grant_s == OWN_ST) begin
        st_v_r <= 1'b0;
      end else if (st_req_in && !st_v_r) begin
        st_v_r    <= 1'b1;
        st_addr_r <= st_addr_in;
        st_len_r  <= st_len_in;
        st_data_r <= st_data_in;
      end
    end
  end

  // Engine command, owner tracking, anti-starvation and gap counters, client acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r       <= 1'b0;
      owner_r       <= OWN_NONE;
      starve_r      <= {SW{1'b0}};
      gap_r         <= {GW{1'b0}};
      eng_write_out <= 1'b0;
      eng_addr_out  <= 32'h0;
      eng_len_out   <= 2'd0;
      eng_wdata_out <= 32'h0;
      if_ack_out    <= 1'b0;
      ld_ack_out    <= 1'b0;
      st_ack_out    <= 1'b0;
      if_data_out   <= 32'h0;
      ld_data_out   <= 32'h0;
    end else if (rdy) begin
      start_r    <= (grant_s != OWN_NONE);
      if_ack_out <= 1'b0;
      ld_ack_out <= 1'b0;
      st_ack_out <= 1'b0;
      case (grant_s)
        OWN_IF: begin
          eng_write_out <= 1'b0;
          eng_addr_out  <= if_addr_r;
          eng_len_out   <= 2'd3;
          eng_wdata_out <= 32'h0;
        end
        OWN_LD: begin
          eng_write_out <= 1'b0;
          eng_addr_out  <= ld_addr_r;
          eng_len_out   <= ld_len_r;
          eng_wdata_out <= 32'h0;
        end
        OWN_ST: begin
          eng_write_out <= 1'b1;
          eng_addr_out  <= st_addr_r;
          eng_len_out   <= st_len_r;
          eng_wdata_out <= st_data_r;
        end
        default: ;
      endcase
      if (grant_s != OWN_NONE) begin
        owner_r <= grant_s;
      end else if (((state_r == S_WAIT) || (state_r == S_DRAIN)) && eng_done_in) begin
        owner_r <= OWN_NONE;
      end
      if (ack_fire_s) begin
        case (owner_r)
          OWN_IF: begin
            if_ack_out  <= 1'b1;
            if_data_out <= eng_rdata_in;
          end
          OWN_LD: begin
            ld_ack_out  <= 1'b1;
            ld_data_out <= ld_extend(eng_rdata_in, eng_len_out);
          end
          OWN_ST:  st_ack_out <= 1'b1;
          default: ;
        endcase
      end
      if (!if_v_r || (grant_s == OWN_IF)) begin
        starve_r <= {SW{1'b0}};
      end else if (((grant_s == OWN_LD) || (grant_s == OWN_ST)) && (starve_r != SW'(STARVE_LIMIT))) begin
        starve_r <= starve_r + SW'(1);
      end
      if ((state_r == S_GAP) && (gap_r != GW'(IO_GAP - 1))) gap_r <= gap_r + GW'(1);
      else                                                  gap_r <= {GW{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_req_sched.sv
// Randomized bench for mem_req_sched against a transaction-level model of slots, grants and acks.
// Directed scenarios first, then random traffic with rdy stalls, flushes, IO throttling and a reset.
module tb_mem_req_sched;
  localparam int LIMIT = 4;
  localparam int GAPC  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rdy = 1'b1, clear_in = 1'b0, io_buffer_full_in = 1'b0;
  logic if_req_in = 1'b0, ld_req_in = 1'b0, st_req_in = 1'b0, eng_done_in = 1'b0;
  logic [31:0] if_addr_in = 32'h0, ld_addr_in = 32'h0, st_addr_in = 32'h0, st_data_in = 32'h0;
  logic [31:0] eng_rdata_in = 32'h0;
  logic [1:0]  ld_len_in = 2'd0, st_len_in = 2'd0;
  logic        if_ack_out, ld_ack_out, st_ack_out, eng_start_out, eng_write_out;
  logic [31:0] if_data_out, ld_data_out, eng_addr_out, eng_wdata_out;
  logic [1:0]  eng_len_out;

  mem_req_sched #(.STARVE_LIMIT(LIMIT), .IO_GAP(GAPC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_in(clear_in), .io_buffer_full_in(io_buffer_full_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_ack_out(if_ack_out), .if_data_out(if_data_out),
    .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_len_in(ld_len_in), .ld_ack_out(ld_ack_out),
    .ld_data_out(ld_data_out), .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_len_in(st_len_in),
    .st_data_in(st_data_in), .st_ack_out(st_ack_out), .eng_start_out(eng_start_out),
    .eng_write_out(eng_write_out), .eng_addr_out(eng_addr_out), .eng_len_out(eng_len_out),
    .eng_wdata_out(eng_wdata_out), .eng_done_in(eng_done_in), .eng_rdata_in(eng_rdata_in)
  );

  int n_cmp = 0, n_mis = 0, cyc = 0;

  // Stimulus for the next edge (index 0 = IF, 1 = LD, 2 = ST).
  bit s_rst, s_rdy = 1'b1, s_clr, s_full, s_ifr, s_ldr, s_str, s_stray, s_auto;
  logic [31:0] s_ia, s_la, s_sa, s_sd, s_rd_next;
  logic [1:0]  s_ll, s_sl;
  int          s_lat = 3;
  bit          cur_rdy = 1'b1;

  // Reference model: pending requests, one outstanding transaction, engine countdown.
  bit          m_v[3], c_out[3], m_busy, m_cancel;
  logic [31:0] m_addr[3], m_wd[3], eng_rd;
  logic [1:0]  m_len[3];
  int          m_own, m_hold, m_starve, eng_cnt;
  bit          e_start, e_write, e_ack[3];
  logic [31:0] e_ifd, e_ldd, e_addr, e_wdata;
  logic [1:0]  e_len;

  logic [31:0] start_addr_q[$];
  int          start_cyc_q[$];
  int          n_ack[3];
  int          last_st_ack_cyc, req_cyc, idx;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_v[c] = 1'b0; c_out[c] = 1'b0; e_ack[c] = 1'b0;
    end
    m_busy = 1'b0; m_cancel = 1'b0; m_hold = 0; m_starve = 0; eng_cnt = 0;
    e_start = 1'b0; e_write = 1'b0; e_ifd = 32'h0; e_ldd = 32'h0;
    e_addr = 32'h0; e_wdata = 32'h0; e_len = 2'd0;
  endtask

  task automatic model_edge(input bit done, input logic [31:0] rd);
    bit pv[3];
    int gnt;
    if (s_rst) begin
      model_reset();
      return;
    end
    if (!s_rdy) return;
    pv = m_v;
    gnt = -1;
    e_start = 1'b0;
    for (int c = 0; c < 3; c++) e_ack[c] = 1'b0;
    if (m_busy && done) begin
      if (!m_cancel && !(s_clr && m_own != 2)) begin
        e_ack[m_own] = 1'b1;
        c_out[m_own] = 1'b0;
        if (m_own == 0) e_ifd = rd;
        if (m_own == 1) e_ldd = (e_len == 2'd0) ? rd % 256 : (e_len == 2'd1) ? rd % 65536 : rd;
      end
      m_hold = (m_own == 2 && e_addr[17:16] == 2'b11) ? GAPC : 0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      eng_cnt--;
      if (s_clr && m_own != 2) m_cancel = 1'b1;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      if (pv[0] && !s_clr && m_starve == LIMIT) gnt = 0;
      else if (pv[2] && !(m_addr[2][17:16] == 2'b11 && s_full)) gnt = 2;
      else if (pv[1] && !s_clr) gnt = 1;
      else if (pv[0] && !s_clr) gnt = 0;
    end
    if (!pv[0] || gnt == 0) m_starve = 0;
    else if (gnt > 0 && m_starve < LIMIT) m_starve++;
    if (gnt >= 0) begin
      m_v[gnt] = 1'b0; m_busy = 1'b1; m_own = gnt; m_cancel = 1'b0;
      e_start = 1'b1; e_write = (gnt == 2); e_addr = m_addr[gnt];
      e_len = (gnt == 0) ? 2'd3 : m_len[gnt];
      e_wdata = (gnt == 2) ? m_wd[2] : 32'h0;
      eng_cnt = s_lat; eng_rd = s_rd_next;
    end
    if (s_ifr && !pv[0]) begin m_v[0] = 1'b1; m_addr[0] = s_ia; c_out[0] = 1'b1; end
    if (s_ldr && !pv[1]) begin m_v[1] = 1'b1; m_addr[1] = s_la; m_len[1] = s_ll; c_out[1] = 1'b1; end
    if (s_str && !pv[2]) begin
      m_v[2] = 1'b1; m_addr[2] = s_sa; m_len[2] = s_sl; m_wd[2] = s_sd; c_out[2] = 1'b1;
    end
    if (s_clr) begin
      m_v[0] = 1'b0; m_v[1] = 1'b0; c_out[0] = 1'b0; c_out[1] = 1'b0;
    end
  endtask

  // One clock: check outputs of the last edge, then drive and model the next edge.
  task automatic step();
    bit done;
    @(negedge clk);
    cyc++;
    chk_eq("eng_start", 128'(eng_start_out), 128'(e_start & cur_rdy));
    chk_eq("acks", 128'({if_ack_out, ld_ack_out, st_ack_out}), 128'({e_ack[0], e_ack[1], e_ack[2]}));
    chk_eq("if_data", 128'(if_data_out), 128'(e_ifd));
    chk_eq("ld_data", 128'(ld_data_out), 128'(e_ldd));
    chk_eq("eng_cmd", 128'({eng_write_out, eng_len_out, eng_addr_out, eng_wdata_out}),
           128'({e_write, e_len, e_addr, e_wdata}));
    if (eng_start_out) begin
      start_addr_q.push_back(eng_addr_out);
      start_cyc_q.push_back(cyc);
    end
    if (if_ack_out) n_ack[0]++;
    if (ld_ack_out) n_ack[1]++;
    if (st_ack_out) begin n_ack[2]++; last_st_ack_cyc = cyc; end
    if (s_auto) begin
      if (!c_out[1]) s_ldr = 1'b1;
      if (!c_out[2]) s_str = 1'b1;
    end
    if (!s_rdy || s_rst) begin s_ifr = 0; s_ldr = 0; s_str = 0; s_clr = 0; end
    if (c_out[0]) s_ifr = 1'b0;
    if (c_out[1]) s_ldr = 1'b0;
    if (c_out[2]) s_str = 1'b0;
    done = (s_rdy && !s_rst && m_busy && eng_cnt == 1) || s_stray;
    rst = s_rst; rdy = s_rdy; clear_in = s_clr; io_buffer_full_in = s_full;
    if_req_in = s_ifr; if_addr_in = s_ia;
    ld_req_in = s_ldr; ld_addr_in = s_la; ld_len_in = s_ll;
    st_req_in = s_str; st_addr_in = s_sa; st_len_in = s_sl; st_data_in = s_sd;
    eng_done_in = done; eng_rdata_in = done ? eng_rd : 32'h0;
    cur_rdy = s_rdy;
    model_edge(done, eng_rd);
    s_ifr = 0; s_ldr = 0; s_str = 0; s_clr = 0; s_stray = 0; s_rst = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_obs();
    start_addr_q.delete(); start_cyc_q.delete();
    for (int c = 0; c < 3; c++) n_ack[c] = 0;
    last_st_ack_cyc = -1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
    return a;
  endfunction

  function automatic logic [1:0] rand_len();
    int k;
    k = $urandom_range(0, 2);
    return (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd3;
  endfunction

  initial begin
    model_reset();
    s_rst = 1'b1; step();
    s_rst = 1'b1; step();
    run(2);

    // Single fetch, engine answers five cycles after start.
    clear_obs(); s_lat = 5; s_rd_next = 32'hDEADBEEF;
    s_ifr = 1'b1; s_ia = 32'h100; req_cyc = cyc + 1; step();
    run(12);
    chk_eq("fetch_data", 128'(if_data_out), 128'(32'hDEADBEEF));
    chk_eq("fetch_starts", 128'(start_addr_q.size()), 128'(1));
    if (start_cyc_q.size() > 0) chk_eq("fetch_latency", 128'(start_cyc_q[0] - req_cyc), 128'(2));
    chk_eq("fetch_other_acks", 128'(n_ack[1] + n_ack[2]), 128'(0));

    // Simultaneous requests: ST, then LD, then IF.
    clear_obs(); s_lat = 3;
    s_ifr = 1; s_ia = 32'h100; s_ldr = 1; s_la = 32'h2000; s_ll = 2'd3;
    s_str = 1; s_sa = 32'h1000; s_sl = 2'd3; s_sd = 32'hCAFEF00D; step();
    run(25);
    chk_eq("order_n", 128'(start_addr_q.size()), 128'(3));
    if (start_addr_q.size() == 3)
      chk_eq("order", 128'({start_addr_q[0], start_addr_q[1], start_addr_q[2]}),
             128'({32'h1000, 32'h2000, 32'h100}));

    // Byte and half loads.
    clear_obs(); s_rd_next = 32'h12345680;
    s_ldr = 1; s_la = 32'h40; s_ll = 2'd0; step(); run(8);
    chk_eq("byte_load", 128'(ld_data_out), 128'(32'h00000080));
    s_ldr = 1; s_la = 32'h42; s_ll = 2'd1; step(); run(8);
    chk_eq("half_load", 128'(ld_data_out), 128'(32'h00005680));

    // Starvation: LD/ST keep re-requesting while IF waits.
    clear_obs(); s_lat = 2;
    s_ifr = 1; s_ia = 32'h4000; s_auto = 1'b1; s_la = 32'h2000; s_sa = 32'h1000; step();
    run(40); s_auto = 1'b0; run(20);
    idx = -1;
    foreach (start_addr_q[i]) if (idx < 0 && start_addr_q[i] == 32'h4000) idx = i;
    chk_eq("starve_grants", 128'(idx), 128'(4));

    // IO store blocked by full buffer, then spaced by the gap.
    clear_obs(); s_lat = 3; s_full = 1'b1;
    s_str = 1; s_sa = 32'h30000; s_sd = 32'h55; s_sl = 2'd0; s_ldr = 1; s_la = 32'h2000; step();
    run(10); s_full = 1'b0; run(2);
    s_ifr = 1; s_ia = 32'h100; step();
    run(15);
    chk_eq("io_n", 128'(start_addr_q.size()), 128'(3));
    if (start_addr_q.size() == 3) begin
      chk_eq("io_order", 128'({start_addr_q[0], start_addr_q[1]}), 128'({32'h2000, 32'h30000}));
      chk_eq("io_gap", 128'(start_cyc_q[2] - last_st_ack_cyc), 128'(3));
    end

    // Flush during LD in WAIT with ST and IF pending.
    clear_obs(); s_lat = 6;
    s_ldr = 1; s_la = 32'h2000; step(); step();
    s_str = 1; s_sa = 32'h1000; s_ifr = 1; s_ia = 32'h100; step();
    s_clr = 1; step();
    run(20);
    chk_eq("clr_ld_ack", 128'(n_ack[1]), 128'(0));
    chk_eq("clr_st_ack", 128'(n_ack[2]), 128'(1));
    chk_eq("clr_starts", 128'(start_addr_q.size()), 128'(2));

    // Reset mid-transaction and a late done afterwards.
    clear_obs(); s_lat = 5;
    s_ldr = 1; s_la = 32'h2000; step(); run(2);
    s_rst = 1; step();
    s_stray = 1; step();
    run(6);
    chk_eq("rst_ld_ack", 128'(n_ack[1]), 128'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s_rdy = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) s_full = ~s_full;
      s_ifr = ($urandom_range(0, 2) == 0); s_ia = $urandom;
      s_ldr = ($urandom_range(0, 2) == 0); s_la = rand_addr(); s_ll = rand_len();
      s_str = ($urandom_range(0, 2) == 0); s_sa = rand_addr(); s_sl = rand_len(); s_sd = $urandom;
      s_clr = ($urandom_range(0, 29) == 0);
      s_lat = $urandom_range(1, 6); s_rd_next = $urandom;
      s_rst = (i == 1500);
      step();
    end
    s_rdy = 1'b1; s_full = 1'b0;
    run(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
